// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-cache, redirect and decode-side signals of the
//            fetch unit, grouped with fetch-unit (master) and environment
//            (slave) views.
// Revision : 1.0
// ============================================================================
interface fetch_unit_if;
  logic        ic_read_en;
  logic [19:0] ic_read_addr;
  logic        ic_fetch_valid;
  logic        ic_cache_miss;
  logic [31:0] ic_rdata;
  logic        redirect;
  logic [19:0] redirect_pc;
  logic        dec_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [19:0] instr_pc;

  modport master (
    output ic_read_en, ic_read_addr, instr_valid, instr, instr_pc,
    input  ic_fetch_valid, ic_cache_miss, ic_rdata, redirect, redirect_pc,
           dec_ready
  );

  modport slave (
    input  ic_read_en, ic_read_addr, instr_valid, instr, instr_pc,
    output ic_fetch_valid, ic_cache_miss, ic_rdata, redirect, redirect_pc,
           dec_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Sequential instruction fetch with one outstanding cache request,
//            a 2-entry {pc, instr} buffer and redirect handling.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [19:0] RESET_PC = 20'h00000
) (
  input  wire logic    CLK,
  input  wire logic    reset,
  fetch_unit_if.master bus
);

  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_REQ      = 2'd1;
  localparam logic [1:0]  S_DROP     = 2'd2;
  localparam logic [19:0] C_RESET_PC = {RESET_PC[19:2], 2'b00};

  logic [1:0]  r_state;
  logic [19:0] r_pc;
  logic [19:0] r_drop_addr;
  logic [19:0] r_fifo_pc  [2];
  logic [31:0] r_fifo_ins [2];
  logic        r_head;
  logic [1:0]  r_count;

  logic [1:0]  w_state_nxt;
  logic        w_pop;
  logic        w_push;
  logic [1:0]  w_cnt_pop;
  logic [1:0]  w_cnt_next;
  logic        w_tail;
  logic [19:0] w_redir_pc;
  logic        w_unused;

  assign w_pop      = (r_count != 2'd0) & bus.dec_ready;
  assign w_push     = (r_state == S_REQ) & bus.ic_fetch_valid & ~bus.redirect;
  assign w_cnt_pop  = r_count - {1'b0, w_pop};
  assign w_cnt_next = w_cnt_pop + {1'b0, w_push};
  // With two slots the tail is head + occupancy modulo 2.
  assign w_tail     = r_head ^ r_count[0];
  assign w_redir_pc = {bus.redirect_pc[19:2], 2'b00};
  assign w_unused   = &{1'b0, bus.ic_cache_miss, bus.redirect_pc[1:0]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!bus.redirect && (w_cnt_pop < 2'd2)) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.redirect)
          w_state_nxt = bus.ic_fetch_valid ? S_IDLE : S_DROP;
        else if (bus.ic_fetch_valid)
          w_state_nxt = (w_cnt_next < 2'd2) ? S_REQ : S_IDLE;
      end
      S_DROP: begin
        if (bus.ic_fetch_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= C_RESET_PC;
      r_drop_addr <= C_RESET_PC;
      r_head      <= 1'b0;
      r_count     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_pc[i]  <= 20'h00000;
        r_fifo_ins[i] <= 32'h00000000;
      end
    end else begin
      r_state <= w_state_nxt;
      if (bus.redirect) begin
        r_pc    <= w_redir_pc;
        r_head  <= 1'b0;
        r_count <= 2'd0;
        // The in-flight address must stay on the bus until its response drains.
        if (r_state == S_REQ) r_drop_addr <= r_pc;
      end else begin
        if (w_push) begin
          r_fifo_pc[w_tail]  <= r_pc;
          r_fifo_ins[w_tail] <= bus.ic_rdata;
          r_pc               <= r_pc + 20'd4;
        end
        if (w_pop) r_head <= ~r_head;
        r_count <= w_cnt_next;
      end
    end
  end

  assign bus.ic_read_en   = (r_state != S_IDLE);
  assign bus.ic_read_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign bus.instr_valid  = (r_count != 2'd0);
  assign bus.instr        = r_fifo_ins[r_head];
  assign bus.instr_pc     = r_fifo_pc[r_head];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed vector table, reset/wrap sequences and randomized
//            traffic against a queue-based reference model for fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  fetch_unit_if bus0 ();
  fetch_unit_if bus1 ();

  fetch_unit u_dut0 (.CLK(clk), .reset(rst0), .bus(bus0));
  fetch_unit #(.RESET_PC(20'hFFFF8)) u_dut1 (.CLK(clk), .reset(rst1), .bus(bus1));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        fv;
    logic [31:0] rdata;
    logic        redir;
    logic [19:0] rpc;
    logic        dr;
    logic        en;
    logic [19:0] addr;
    logic        vld;
    logic [19:0] ipc;
    logic [31:0] ins;
  } vec_t;

  function automatic vec_t mk(input logic fv, input logic [31:0] rdata, input logic redir,
                              input logic [19:0] rpc, input logic dr, input logic en,
                              input logic [19:0] addr, input logic vld,
                              input logic [19:0] ipc, input logic [31:0] ins);
    vec_t v;
    v.fv = fv; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.dr = dr;
    v.en = en; v.addr = addr; v.vld = vld; v.ipc = ipc; v.ins = ins;
    return v;
  endfunction

  typedef struct {
    logic [19:0] pc;
    logic [31:0] ins;
  } ent_t;

  localparam logic [31:0] A0  = 32'h00000013;
  localparam logic [31:0] A4  = 32'h00100093;
  localparam logic [31:0] A8  = 32'hBAD0BAD0;
  localparam logic [31:0] BAD = 32'hDEADBEEF;
  localparam logic [31:0] B0  = 32'h11111111;
  localparam logic [31:0] B4  = 32'h22222222;
  localparam logic [31:0] B8  = 32'h33333333;
  localparam logic [31:0] D0  = 32'h44444444;

  vec_t tbl [19];

  task automatic drive0(input logic fv, input logic [31:0] rd, input logic redir,
                        input logic [19:0] rpc, input logic dr);
    bus0.ic_fetch_valid = fv;
    bus0.ic_rdata       = rd;
    bus0.redirect       = redir;
    bus0.redirect_pc    = rpc;
    bus0.dec_ready      = dr;
  endtask

  initial begin
    ent_t        q[$];
    logic [19:0] m_pc, m_req;
    logic        m_out, m_drop;
    logic [19:0] expv [3];
    int          got, last;

    tbl[0]  = mk(0, 0,   0, 20'h00000, 0, 0, 20'h00000, 0, 20'h00000, 0);
    tbl[1]  = mk(1, A0,  0, 20'h00000, 0, 1, 20'h00000, 0, 20'h00000, 0);
    tbl[2]  = mk(1, A4,  0, 20'h00000, 0, 1, 20'h00004, 1, 20'h00000, A0);
    tbl[3]  = mk(1, A8,  0, 20'h00000, 0, 0, 20'h00008, 1, 20'h00000, A0);
    tbl[4]  = mk(0, 0,   0, 20'h00000, 1, 0, 20'h00008, 1, 20'h00000, A0);
    tbl[5]  = mk(0, 0,   1, 20'h00103, 0, 1, 20'h00008, 1, 20'h00004, A4);
    tbl[6]  = mk(0, 0,   0, 20'h00000, 0, 1, 20'h00008, 0, 20'h00000, 0);
    tbl[7]  = mk(0, 0,   0, 20'h00000, 0, 1, 20'h00008, 0, 20'h00000, 0);
    tbl[8]  = mk(1, BAD, 0, 20'h00000, 0, 1, 20'h00008, 0, 20'h00000, 0);
    tbl[9]  = mk(0, 0,   0, 20'h00000, 1, 0, 20'h00100, 0, 20'h00000, 0);
    tbl[10] = mk(1, B0,  0, 20'h00000, 1, 1, 20'h00100, 0, 20'h00000, 0);
    tbl[11] = mk(1, B4,  0, 20'h00000, 1, 1, 20'h00104, 1, 20'h00100, B0);
    tbl[12] = mk(1, B8,  0, 20'h00000, 0, 1, 20'h00108, 1, 20'h00104, B4);
    tbl[13] = mk(1, BAD, 1, 20'h2000A, 1, 0, 20'h0010C, 1, 20'h00104, B4);
    tbl[14] = mk(0, 0,   0, 20'h00000, 1, 0, 20'h20008, 0, 20'h00000, 0);
    tbl[15] = mk(1, D0,  0, 20'h00000, 0, 1, 20'h20008, 0, 20'h00000, 0);
    tbl[16] = mk(1, BAD, 1, 20'h00040, 1, 1, 20'h2000C, 1, 20'h20008, D0);
    tbl[17] = mk(0, 0,   0, 20'h00000, 0, 0, 20'h00040, 0, 20'h00000, 0);
    tbl[18] = mk(0, 0,   0, 20'h00000, 0, 1, 20'h00040, 0, 20'h00000, 0);

    rst0 = 1'b1;
    rst1 = 1'b1;
    drive0(0, 0, 0, 0, 0);
    bus0.ic_cache_miss  = 1'b0;
    bus1.ic_fetch_valid = 1'b1;
    bus1.ic_rdata       = 32'h00000013;
    bus1.redirect       = 1'b0;
    bus1.redirect_pc    = 20'h00000;
    bus1.dec_ready      = 1'b1;
    bus1.ic_cache_miss  = 1'b0;

    // Wrap-around from a high reset PC with a free-running cache and decoder.
    repeat (2) @(negedge clk);
    check("dut1.reset_en",   {31'd0, bus1.ic_read_en},   32'd0);
    check("dut1.reset_addr", {12'd0, bus1.ic_read_addr}, 32'h000FFFF8);
    rst1 = 1'b0;
    expv[0] = 20'hFFFF8; expv[1] = 20'hFFFFC; expv[2] = 20'h00000;
    got = 0; last = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus1.instr_valid && got < 3) begin
        check($sformatf("dut1.pc%0d", got), {12'd0, bus1.instr_pc}, {12'd0, expv[got]});
        if (got > 0) check($sformatf("dut1.gap%0d", got), c - last, 1);
        last = c;
        got++;
      end
    end
    check("dut1.count", got, 3);

    // Reset values, then the directed vector table starting at release.
    @(negedge clk);
    check("rst.en",    {31'd0, bus0.ic_read_en},   32'd0);
    check("rst.addr",  {12'd0, bus0.ic_read_addr}, 32'd0);
    check("rst.valid", {31'd0, bus0.instr_valid},  32'd0);
    check("rst.instr", bus0.instr,                 32'd0);
    check("rst.pc",    {12'd0, bus0.instr_pc},     32'd0);
    rst0 = 1'b0;
    for (int i = 0; i < 19; i++) begin
      check($sformatf("vec%0d.en", i),    {31'd0, bus0.ic_read_en},   {31'd0, tbl[i].en});
      check($sformatf("vec%0d.addr", i),  {12'd0, bus0.ic_read_addr}, {12'd0, tbl[i].addr});
      check($sformatf("vec%0d.valid", i), {31'd0, bus0.instr_valid},  {31'd0, tbl[i].vld});
      if (tbl[i].vld) begin
        check($sformatf("vec%0d.ipc", i),   {12'd0, bus0.instr_pc}, {12'd0, tbl[i].ipc});
        check($sformatf("vec%0d.instr", i), bus0.instr,             tbl[i].ins);
      end
      drive0(tbl[i].fv, tbl[i].rdata, tbl[i].redir, tbl[i].rpc, tbl[i].dr);
      @(negedge clk);
    end

    // Reset pulsed while a request for 0x40 is outstanding; a stale response follows.
    check("pre_rst.en", {31'd0, bus0.ic_read_en}, 32'd1);
    rst0 = 1'b1;
    drive0(0, 0, 0, 0, 0);
    #1;
    check("midrst.en",    {31'd0, bus0.ic_read_en},   32'd0);
    check("midrst.addr",  {12'd0, bus0.ic_read_addr}, 32'd0);
    check("midrst.valid", {31'd0, bus0.instr_valid},  32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    drive0(1, BAD, 0, 0, 0);
    @(negedge clk);
    check("stale.en",    {31'd0, bus0.ic_read_en},   32'd1);
    check("stale.addr",  {12'd0, bus0.ic_read_addr}, 32'd0);
    check("stale.valid", {31'd0, bus0.instr_valid},  32'd0);
    drive0(1, A0, 0, 0, 0);
    @(negedge clk);
    check("post_rst.valid", {31'd0, bus0.instr_valid}, 32'd1);
    check("post_rst.pc",    {12'd0, bus0.instr_pc},    32'd0);
    check("post_rst.instr", bus0.instr,                A0);
    drive0(0, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    q.delete();
    m_pc = 20'h00000; m_req = 20'h00000; m_out = 1'b0; m_drop = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic        fv, redir, dr, pop;
      logic [31:0] rd;
      logic [19:0] rpc;
      check("rnd.en",    {31'd0, bus0.ic_read_en}, {31'd0, m_out});
      check("rnd.addr",  {12'd0, bus0.ic_read_addr}, {12'd0, (m_out ? m_req : m_pc)});
      check("rnd.valid", {31'd0, bus0.instr_valid}, {31'd0, (q.size() != 0)});
      if (q.size() != 0) begin
        check("rnd.ipc",   {12'd0, bus0.instr_pc}, {12'd0, q[0].pc});
        check("rnd.instr", bus0.instr,             q[0].ins);
      end
      fv    = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 9) == 0);
      dr    = ($urandom_range(0, 1) == 1);
      rd    = $urandom;
      rpc   = 20'($urandom);
      bus0.ic_cache_miss = ($urandom_range(0, 1) == 1);
      drive0(fv, rd, redir, rpc, dr);

      pop = (q.size() != 0) && dr;
      if (redir) begin
        q.delete();
        if (m_out && fv) begin
          m_out = 1'b0; m_drop = 1'b0;
        end else if (m_out) begin
          m_drop = 1'b1;
        end
        m_pc = {rpc[19:2], 2'b00};
      end else begin
        if (pop) void'(q.pop_front());
        if (m_out) begin
          if (fv) begin
            if (!m_drop) begin
              q.push_back('{m_req, rd});
              m_pc  = m_pc + 20'd4;
              m_out = (q.size() < 2);
              m_req = m_pc;
            end else begin
              m_out = 1'b0; m_drop = 1'b0;
            end
          end
        end else if (q.size() < 2) begin
          m_out = 1'b1;
          m_req = m_pc;
        end
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
